// File: rtl/secded64_pkg.sv
// Shared SECDED (72,64) definitions: position map, check masks,
// codeword field offsets and injector encodings.
package secded64_pkg;

    localparam int DATA_W   = 64;
    localparam int CHK_W    = 7;
    localparam int CODE_W   = 72;
    localparam int POS_W    = 7;
    localparam int DATA_LSB = 0;
    localparam int CHK_LSB  = 64;
    localparam int PAR_BIT  = 71;

    typedef enum logic [1:0] {
        INJ_NONE   = 2'b00,
        INJ_SINGLE = 2'b01,
        INJ_DOUBLE = 2'b10,
        INJ_RSVD   = 2'b11
    } inj_mode_e;

    typedef struct packed {
        inj_mode_e        mode;
        logic [POS_W-1:0] pos0;
        logic [POS_W-1:0] pos1;
    } inj_tag_t;

    localparam inj_tag_t TAG_NONE = '{
        mode: INJ_NONE,
        pos0: '0,
        pos1: '0
    };

    typedef logic [DATA_W-1:0][POS_W-1:0] pos_map_t;
    typedef logic [CHK_W-1:0][DATA_W-1:0] chk_mask_t;

    // d[k] sits at the (k+1)-th non-power-of-two position in 1..71
    function automatic pos_map_t gen_pos_map();
        pos_map_t m;
        int k;
        m = '0;
        k = 0;
        for (int p = 1; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                m[k] = POS_W'(p);
                k++;
            end
        end
        return m;
    endfunction

    localparam pos_map_t DATA_POS = gen_pos_map();

    function automatic chk_mask_t gen_chk_mask();
        chk_mask_t m;
        m = '0;
        for (int i = 0; i < CHK_W; i++) begin
            for (int k = 0; k < DATA_W; k++) begin
                m[i][k] = DATA_POS[k][i];
            end
        end
        return m;
    endfunction

    localparam chk_mask_t CHK_MASK = gen_chk_mask();

endpackage

// File: rtl/secded64_chk_gen.sv
// Combinational check-bit generator, d[63:0] -> c[6:0].
// Shared with the decoder for syndrome generation.
module secded64_chk_gen
    import secded64_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CHK_W-1:0]  chk
);

    always_comb begin
        chk = '0;
        for (int i = 0; i < CHK_W; i++) begin
            chk[i] = ^(data & CHK_MASK[i]);
        end
    end

endmodule

// File: rtl/secded_enc64.sv
// SECDED (72,64) encoder: two-stage valid/ready pipeline with
// one-shot fault injector and delivered-word counter.
module secded_enc64
    import secded64_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CODE_W-1:0]  out_code,
    input  logic               inj_arm,
    input  logic [1:0]         inj_mode,
    input  logic [POS_W-1:0]   inj_pos0,
    input  logic [POS_W-1:0]   inj_pos1,
    output logic               inj_pending,
    output logic [CNT_W-1:0]   word_cnt
);

    localparam logic [CODE_W-1:0] ONE = CODE_W'(1);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [CHK_W-1:0]  s1_chk;
    inj_tag_t          s1_tag;
    inj_tag_t          inj_lat;
    inj_tag_t          arm_tag;
    inj_tag_t          acc_tag;
    logic [CHK_W-1:0]  chk;
    logic              s2_free;
    logic              in_acc;
    logic              out_acc;
    logic              arm_ok;
    logic [CODE_W-1:0] code_raw;
    logic [CODE_W-1:0] flip;

    secded64_chk_gen u_chk_gen (
        .data (in_data),
        .chk  (chk)
    );

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;

    assign arm_ok = inj_arm && !inj_pending &&
                    (inj_mode == INJ_SINGLE || inj_mode == INJ_DOUBLE);

    assign arm_tag = '{
        mode: inj_mode_e'(inj_mode),
        pos0: inj_pos0,
        pos1: inj_pos1
    };

    // An arm in the same cycle as an accept goes straight onto that word
    always_comb begin
        acc_tag = TAG_NONE;
        unique case (1'b1)
            inj_pending: acc_tag = inj_lat;
            arm_ok:      acc_tag = arm_tag;
            default:     acc_tag = TAG_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inj_pending <= 1'b0;
            inj_lat     <= TAG_NONE;
        end else if (in_acc) begin
            inj_pending <= 1'b0;
        end else if (arm_ok) begin
            inj_pending <= 1'b1;
            inj_lat     <= arm_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_chk   <= '0;
            s1_tag   <= TAG_NONE;
        end else if (in_acc) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_chk   <= chk;
            s1_tag   <= acc_tag;
        end else if (s2_free) begin
            s1_valid <= 1'b0;
        end
    end

    // Shifts past bit 71 fall off, so out-of-range positions flip nothing
    always_comb begin
        flip = '0;
        if (s1_tag.mode == INJ_SINGLE || s1_tag.mode == INJ_DOUBLE) begin
            flip = flip ^ (ONE << s1_tag.pos0);
        end
        if (s1_tag.mode == INJ_DOUBLE) begin
            flip = flip ^ (ONE << s1_tag.pos1);
        end
    end

    always_comb begin
        code_raw = '0;
        code_raw[DATA_LSB +: DATA_W] = s1_data;
        code_raw[CHK_LSB +: CHK_W]   = s1_chk;
        code_raw[PAR_BIT]            = ^s1_data ^ ^s1_chk;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_code  <= '0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_code <= code_raw ^ flip;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (out_acc) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_secded_enc64.sv
// Directed bench for secded_enc64: reset, encoding vectors, injector,
// streaming, backpressure, mid-run reset and counter wrap.
module tb_secded_enc64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;
    logic        inj_arm;
    logic [1:0]  inj_mode;
    logic [6:0]  inj_pos0;
    logic [6:0]  inj_pos1;

    logic        in_ready;
    logic        out_valid;
    logic [71:0] out_code;
    logic        inj_pending;
    logic [15:0] word_cnt;

    logic        in_ready4;
    logic        out_valid4;
    logic [71:0] out_code4;
    logic        inj_pending4;
    logic [3:0]  word_cnt4;

    int total = 0;
    int bad   = 0;

    logic [71:0] exp_q[$];

    always #5 clk = ~clk;

    secded_enc64 #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_code    (out_code),
        .inj_arm     (inj_arm),
        .inj_mode    (inj_mode),
        .inj_pos0    (inj_pos0),
        .inj_pos1    (inj_pos1),
        .inj_pending (inj_pending),
        .word_cnt    (word_cnt)
    );

    secded_enc64 #(.CNT_W(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready4),
        .in_data     (in_data),
        .out_valid   (out_valid4),
        .out_ready   (out_ready),
        .out_code    (out_code4),
        .inj_arm     (inj_arm),
        .inj_mode    (inj_mode),
        .inj_pos0    (inj_pos0),
        .inj_pos1    (inj_pos1),
        .inj_pending (inj_pending4),
        .word_cnt    (word_cnt4)
    );

    function automatic logic [71:0] ref_code(
        input logic [63:0] d,
        input logic [1:0]  m,
        input logic [6:0]  a,
        input logic [6:0]  b
    );
        logic [6:0]  c;
        logic [71:0] r;
        int k;
        c = '0;
        k = 0;
        for (int p = 1; p <= 71; p++) begin
            if ((p & (p - 1)) != 0) begin
                for (int i = 0; i < 7; i++) begin
                    if (((p >> i) & 1) == 1) c[i] = c[i] ^ d[k];
                end
                k++;
            end
        end
        r = {^d ^ ^c, c, d};
        if ((m == 2'd1 || m == 2'd2) && a < 7'd72) r[a] = ~r[a];
        if (m == 2'd2 && b < 7'd72) r[b] = ~r[b];
        return r;
    endfunction

    logic [63:0] vec [8] = '{
        64'h0123_4567_89ab_cdef, 64'hffff_ffff_ffff_ffff,
        64'h8000_0000_0000_0000, 64'h0000_0000_0000_0002,
        64'hdead_beef_cafe_f00d, 64'h5555_aaaa_5555_aaaa,
        64'h0000_0001_0000_0000, 64'h7fff_0000_ffff_0001
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        inj_arm   = 1'b0;
        inj_mode  = 2'b00;
        inj_pos0  = '0;
        inj_pos1  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send_word(input logic [63:0] d, output logic v,
                             output logic [71:0] code);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        inj_arm  = 1'b0;
        tick();
        v    = out_valid;
        code = out_code;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_in_ready got=%b exp=1", in_ready);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_out_valid got=%b exp=0", out_valid);
        end
        total++;
        if (out_code !== 72'h0) begin
            bad++;
            $display("FAIL rst_out_code got=%h exp=0", out_code);
        end
        total++;
        if (inj_pending !== 1'b0) begin
            bad++;
            $display("FAIL rst_inj_pending got=%b exp=0", inj_pending);
        end
        total++;
        if (word_cnt !== 16'd0) begin
            bad++;
            $display("FAIL rst_word_cnt got=%0d exp=0", word_cnt);
        end
    endtask

    task automatic test_latency();
        in_valid  = 1'b1;
        in_data   = 64'h0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL lat_n1_valid got=%b exp=0", out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_code !== 72'h0) begin
            bad++;
            $display("FAIL lat_zero got=%b/%h exp=1/0", out_valid, out_code);
        end
        tick();
        total++;
        if (word_cnt !== 16'd1) begin
            bad++;
            $display("FAIL lat_word_cnt got=%0d exp=1", word_cnt);
        end
    endtask

    task automatic test_encode();
        logic        v;
        logic [71:0] c;
        send_word(64'h1, v, c);
        total++;
        if (v !== 1'b1 || c !== 72'h83_0000_0000_0000_0001) begin
            bad++;
            $display("FAIL enc_one got=%b/%h exp=1/830000000000000001", v, c);
        end
        send_word(64'hffff_ffff_ffff_ffff, v, c);
        total++;
        if (c !== ref_code(64'hffff_ffff_ffff_ffff, 2'd0, 7'd0, 7'd0)) begin
            bad++;
            $display("FAIL enc_ones got=%h exp=%h", c,
                     ref_code(64'hffff_ffff_ffff_ffff, 2'd0, 7'd0, 7'd0));
        end
        send_word(64'h8000_0000_0000_0000, v, c);
        total++;
        if (c !== ref_code(64'h8000_0000_0000_0000, 2'd0, 7'd0, 7'd0)) begin
            bad++;
            $display("FAIL enc_msb got=%h exp=%h", c,
                     ref_code(64'h8000_0000_0000_0000, 2'd0, 7'd0, 7'd0));
        end
    endtask

    task automatic test_inject();
        logic        v;
        logic [71:0] c;
        inj_arm  = 1'b1;
        inj_mode = 2'b01;
        inj_pos0 = 7'd5;
        tick();
        inj_arm = 1'b0;
        total++;
        if (inj_pending !== 1'b1) begin
            bad++;
            $display("FAIL inj_armed got=%b exp=1", inj_pending);
        end
        inj_arm  = 1'b1;
        inj_mode = 2'b10;
        inj_pos0 = 7'd9;
        inj_pos1 = 7'd10;
        tick();
        inj_arm  = 1'b0;
        in_valid = 1'b1;
        in_data  = 64'h0;
        tick();
        in_valid = 1'b0;
        total++;
        if (inj_pending !== 1'b0) begin
            bad++;
            $display("FAIL inj_consumed got=%b exp=0", inj_pending);
        end
        tick();
        total++;
        if (out_code !== 72'h20) begin
            bad++;
            $display("FAIL inj_single got=%h exp=20", out_code);
        end
        inj_arm  = 1'b1;
        inj_mode = 2'b10;
        inj_pos0 = 7'd5;
        inj_pos1 = 7'd70;
        tick();
        inj_arm = 1'b0;
        send_word(64'h0, v, c);
        total++;
        if (c !== 72'h40_0000_0000_0000_0020) begin
            bad++;
            $display("FAIL inj_double got=%h exp=400000000000000020", c);
        end
        inj_arm  = 1'b1;
        inj_mode = 2'b01;
        inj_pos0 = 7'd71;
        in_valid = 1'b1;
        in_data  = 64'h1;
        tick();
        in_valid = 1'b0;
        inj_arm  = 1'b0;
        total++;
        if (inj_pending !== 1'b0) begin
            bad++;
            $display("FAIL inj_same_cycle_pend got=%b exp=0", inj_pending);
        end
        tick();
        total++;
        if (out_code !== 72'h03_0000_0000_0000_0001) begin
            bad++;
            $display("FAIL inj_same_cycle got=%h exp=030000000000000001", out_code);
        end
        inj_arm  = 1'b1;
        inj_mode = 2'b01;
        inj_pos0 = 7'd100;
        tick();
        inj_arm = 1'b0;
        send_word(64'h1, v, c);
        total++;
        if (c !== 72'h83_0000_0000_0000_0001) begin
            bad++;
            $display("FAIL inj_out_of_range got=%h exp=830000000000000001", c);
        end
        inj_arm  = 1'b1;
        inj_mode = 2'b10;
        inj_pos0 = 7'd7;
        inj_pos1 = 7'd7;
        tick();
        inj_arm = 1'b0;
        send_word(64'h0, v, c);
        total++;
        if (c !== 72'h0) begin
            bad++;
            $display("FAIL inj_cancel got=%h exp=0", c);
        end
        inj_arm  = 1'b1;
        inj_mode = 2'b11;
        inj_pos0 = 7'd3;
        tick();
        inj_arm = 1'b0;
        total++;
        if (inj_pending !== 1'b0) begin
            bad++;
            $display("FAIL inj_mode11 got=%b exp=0", inj_pending);
        end
    endtask

    task automatic test_back_to_back();
        int nxt = 0;
        int dlv = 0;
        int first = -1;
        logic [71:0] e;
        exp_q.delete();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            in_valid = (nxt < 8);
            in_data  = vec[nxt % 8];
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_code(vec[nxt], 2'd0, 7'd0, 7'd0));
                nxt++;
            end
            if (out_valid && out_ready) begin
                if (first < 0) first = cyc;
                e = exp_q.pop_front();
                total++;
                if (out_code !== e) begin
                    bad++;
                    $display("FAIL b2b_word%0d got=%h exp=%h", dlv, out_code, e);
                end
                dlv++;
            end
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (first != 2 || dlv != 8 || nxt != 8) begin
            bad++;
            $display("FAIL b2b_rate got=first%0d/acc%0d/dlv%0d exp=2/8/8",
                     first, nxt, dlv);
        end
    endtask

    task automatic test_backpressure();
        int nxt = 0;
        int dlv = 0;
        logic [71:0] e;
        exp_q.delete();
        inj_arm  = 1'b1;
        inj_mode = 2'b01;
        inj_pos0 = 7'd20;
        tick();
        inj_arm = 1'b0;
        for (int cyc = 0; cyc < 300 && dlv < 8; cyc++) begin
            out_ready = (cyc < 3) ? 1'b0 : 1'($urandom_range(0, 1));
            in_valid  = (nxt < 8);
            in_data   = vec[nxt % 8];
            #1;
            if (cyc == 2) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_full_ready got=%b exp=0", in_ready);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_code(vec[nxt], (nxt == 0) ? 2'd1 : 2'd0,
                                         7'd20, 7'd0));
                nxt++;
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL bp_extra got=%h exp=none", out_code);
                end else begin
                    e = exp_q.pop_front();
                    if (out_code !== e) begin
                        bad++;
                        $display("FAIL bp_word%0d got=%h exp=%h", dlv, out_code, e);
                    end
                end
                dlv++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        total++;
        if (dlv != 8 || exp_q.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_count got=dlv%0d/left%0d/v%b exp=8/0/0",
                     dlv, exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h1234;
        tick();
        in_data = 64'h5678;
        tick();
        in_valid = 1'b0;
        inj_arm  = 1'b1;
        inj_mode = 2'b01;
        inj_pos0 = 7'd2;
        tick();
        inj_arm = 1'b0;
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || inj_pending !== 1'b1) begin
            bad++;
            $display("FAIL rmid_pre got=%b%b%b exp=101",
                     out_valid, in_ready, inj_pending);
        end
        rst_n = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0 || inj_pending !== 1'b0 || word_cnt !== 16'd0) begin
            bad++;
            $display("FAIL rmid_post got=%b/%b/%0d exp=0/0/0",
                     out_valid, inj_pending, word_cnt);
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rmid_flushed got=%b/%b exp=0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 64'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (word_cnt4 !== 4'd1) begin
            bad++;
            $display("FAIL wrap_cnt4 got=%0d exp=1", word_cnt4);
        end
        total++;
        if (word_cnt !== 16'd17) begin
            bad++;
            $display("FAIL wrap_cnt16 got=%0d exp=17", word_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_latency();
        test_encode();
        test_inject();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
